// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - bridge-to-serializer handshake and status bundle
interface uart_tx_serializer_if #(
  parameter int N = 8
);
  logic         tx_start;
  logic [N-1:0] tx_data;
  logic         tx;
  logic         uart_busy;
  logic         end_tx;

  modport master (
    output tx_start,
    output tx_data,
    input  tx,
    input  uart_busy,
    input  end_tx
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx,
    output uart_busy,
    output end_tx
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART frame serializer with optional parity and 1/2 stop bits
module uart_tx_serializer #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_serializer_if.slave  bus
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(N + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(N - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
  localparam logic          ODD        = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [N-1:0]  shift_reg, shift_reg_n;
  logic          parity, parity_n;
  logic          tx_q, tx_n;
  logic          busy_q, busy_n;
  logic          end_q, end_n;
  logic          bit_done;

  assign bus.tx        = tx_q;
  assign bus.uart_busy = busy_q;
  assign bus.end_tx    = end_q;

  // State, counters and the registered line/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      parity    <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      end_q     <= 1'b1;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_reg_n;
      parity    <= parity_n;
      tx_q      <= tx_n;
      busy_q    <= busy_n;
      end_q     <= end_n;
    end
  end

  // Next-state logic; tx is computed one cycle ahead so the line comes straight off a flop.
  always_comb begin
    state_n     = state;
    timer_n     = timer;
    bit_cnt_n   = bit_cnt;
    shift_reg_n = shift_reg;
    parity_n    = parity;
    tx_n        = tx_q;
    busy_n      = busy_q;
    end_n       = end_q;
    bit_done    = (timer == TIMER_LAST);

    // Every state change happens on a bit boundary, so wrapping here also clears the timer on entry.
    if (state != IDLE) begin
      timer_n = bit_done ? '0 : timer + TW'(1);
    end

    case (state)
      IDLE: begin
        tx_n    = 1'b1;
        busy_n  = 1'b0;
        timer_n = '0;
        if (bus.tx_start) begin
          shift_reg_n = bus.tx_data;
          parity_n    = (^bus.tx_data) ^ ODD;
          bit_cnt_n   = '0;
          tx_n        = 1'b0;
          busy_n      = 1'b1;
          end_n       = 1'b0;
          state_n     = START;
        end
      end
      START: begin
        if (bit_done) begin
          tx_n        = shift_reg[0];
          shift_reg_n = shift_reg >> 1;
          bit_cnt_n   = '0;
          state_n     = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_n = '0;
            if (PARITY_EN != 0) begin
              tx_n    = parity;
              state_n = PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = STOP;
            end
          end else begin
            tx_n        = shift_reg[0];
            shift_reg_n = shift_reg >> 1;
            bit_cnt_n   = bit_cnt + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          tx_n      = 1'b1;
          bit_cnt_n = '0;
          state_n   = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (bit_cnt == STOP_LAST) begin
            tx_n      = 1'b1;
            busy_n    = 1'b0;
            end_n     = 1'b1;
            bit_cnt_n = '0;
            state_n   = IDLE;
          end else begin
            bit_cnt_n = bit_cnt + BW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench over several frame configurations
module tb_uart_tx_serializer;
  localparam int NCFG = 6;
  localparam int CFG_N  [NCFG] = '{8, 8, 8, 8, 5, 9};
  localparam int CFG_C  [NCFG] = '{4, 4, 4, 4, 3, 2};
  localparam int CFG_PE [NCFG] = '{0, 1, 1, 0, 1, 0};
  localparam int CFG_PO [NCFG] = '{0, 0, 1, 0, 1, 0};
  localparam int CFG_SB [NCFG] = '{1, 1, 1, 2, 2, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_s = 1'b0;
  logic [8:0] data_s = '0;
  logic       tx_w   [NCFG];
  logic       busy_w [NCFG];
  logic       end_w  [NCFG];

  int         cyc = 0;
  bit         mon_en = 1'b0;
  int         checks = 0;
  int         errors = 0;

  int         exp_start [NCFG][$];
  logic [8:0] exp_data  [NCFG][$];
  int         free_edge [NCFG];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int NI = CFG_N[g];
    uart_tx_serializer_if #(.N(NI)) bus ();
    assign bus.tx_start = start_s;
    assign bus.tx_data  = data_s[NI-1:0];
    assign tx_w[g]      = bus.tx;
    assign busy_w[g]    = bus.uart_busy;
    assign end_w[g]     = bus.end_tx;
    uart_tx_serializer #(
      .N(NI), .CLKS_PER_BIT(CFG_C[g]), .PARITY_EN(CFG_PE[g]),
      .PARITY_ODD(CFG_PO[g]), .STOP_BITS(CFG_SB[g])
    ) dut (
      .clk(clk), .reset(reset), .bus(bus)
    );
  end

  function automatic int frame_len(input int i);
    return CFG_C[i] * (1 + CFG_N[i] + CFG_PE[i] + CFG_SB[i]);
  endfunction

  // Line level of frame bit k: start, LSB-first data, optional parity, stop.
  function automatic logic line_bit(input int i, input logic [8:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= CFG_N[i]) return logic'((d >> (k - 1)) & 9'd1);
    if (k == CFG_N[i] + 1 && CFG_PE[i] != 0)
      return logic'(($countones(d) % 2) != 0) ^ logic'(CFG_PO[i] != 0);
    return 1'b1;
  endfunction

  function automatic int max_free();
    int m = 0;
    for (int i = 0; i < NCFG; i++) if (free_edge[i] > m) m = free_edge[i];
    return m;
  endfunction

  // Monitor: every cycle, compare each line against the head of its expected-frame queue.
  always @(negedge clk) begin
    logic [2:0] exp_v;
    logic [2:0] act_v;
    int         off;
    bit         pop_now;
    if (mon_en) begin
      for (int i = 0; i < NCFG; i++) begin
        exp_v   = 3'b101;
        pop_now = 1'b0;
        if (exp_start[i].size() > 0 && cyc >= exp_start[i][0]) begin
          off   = cyc - exp_start[i][0];
          exp_v = {line_bit(i, exp_data[i][0], off / CFG_C[i]), 1'b1, 1'b0};
          if (off == frame_len(i) - 1) pop_now = 1'b1;
        end
        act_v  = {tx_w[i], busy_w[i], end_w[i]};
        checks = checks + 1;
        if (act_v !== exp_v) begin
          errors = errors + 1;
          $display("FAIL line%0d cycle %0d tx/busy/end: got %b expected %b", i, cyc, act_v, exp_v);
        end
        if (pop_now) begin
          void'(exp_start[i].pop_front());
          void'(exp_data[i].pop_front());
        end
      end
    end
  end

  // One stimulus cycle; the model accepts a start only where the frame rules say the line is idle.
  task automatic drive_cycle(input logic s, input logic [8:0] d);
    start_s = s;
    data_s  = d;
    if (s && !reset) begin
      for (int i = 0; i < NCFG; i++) begin
        if (cyc + 1 >= free_edge[i]) begin
          exp_start[i].push_back(cyc + 1);
          exp_data[i].push_back(d & 9'((1 << CFG_N[i]) - 1));
          free_edge[i] = cyc + 1 + frame_len(i) + 1;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic [8:0] d);
    drive_cycle(1'b1, d);
    start_s = 1'b0;
    data_s  = 9'($urandom_range(0, 511));
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) drive_cycle(1'b0, data_s);
  endtask

  task automatic wait_idle();
    while (cyc + 1 < max_free()) drive_cycle(1'b0, data_s);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NCFG; i++) begin
      exp_start[i].delete();
      exp_data[i].delete();
      free_edge[i] = cyc + 1;
    end
    reset = 1'b0;
  endtask

  initial begin
    int e0;
    int w;
    for (int i = 0; i < NCFG; i++) free_edge[i] = 0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    idle_cycles(2);
    do_reset();
    idle_cycles(3);

    // Basic frame, parity and two-stop-bit patterns.
    pulse(9'h0A5); wait_idle(); idle_cycles(2);
    pulse(9'h007); wait_idle(); idle_cycles(2);
    pulse(9'h000); wait_idle(); idle_cycles(2);

    // Start strobe in the middle of a frame must be ignored.
    pulse(9'h03C); idle_cycles(15); pulse(9'h0FF); wait_idle(); idle_cycles(5);

    // Reset during data bit 3 of the 4-clock configurations.
    e0 = cyc + 1;
    pulse(9'h096);
    while (cyc < e0 + 17) idle_cycles(1);
    do_reset();
    idle_cycles(2);
    pulse(9'h0C3); wait_idle(); idle_cycles(2);

    // Back-to-back, bridge style: next strobe as soon as busy is seen low.
    pulse(9'h055);
    w = 0;
    while (busy_w[0] && w < 200) begin idle_cycles(1); w++; end
    checks = checks + 1;
    if (busy_w[0]) begin
      errors = errors + 1;
      $display("FAIL b2b_busy_timeout: busy still %b after %0d cycles, required 0", busy_w[0], w);
    end
    pulse(9'h0AA); wait_idle(); idle_cycles(2);

    // Strobe held high re-triggers on every return to idle.
    for (int k = 0; k < 70; k++) drive_cycle(1'b1, 9'($urandom_range(0, 511)));
    start_s = 1'b0;
    wait_idle(); idle_cycles(2);

    // Random words, gaps and stray strobes.
    for (int t = 0; t < 40; t++) begin
      pulse(9'($urandom_range(0, 511)));
      if ($urandom_range(0, 3) == 0) begin
        idle_cycles($urandom_range(1, 20));
        pulse(9'($urandom_range(0, 511)));
      end
      idle_cycles($urandom_range(0, 50));
    end
    wait_idle(); idle_cycles(4);

    for (int i = 0; i < NCFG; i++) begin
      checks = checks + 1;
      if (exp_start[i].size() != 0) begin
        errors = errors + 1;
        $display("FAIL line%0d leftover_frames: got %0d pending, required 0", i, exp_start[i].size());
      end
    end
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
